// File: rtl/gn_stream.sv
// gn_stream: streaming group normalisation. Collects one group of samples,
// derives mean and 1/sd with bit-serial sqrt and divide, then replays the
// buffered group as saturated signed fixed-point normalised samples.
module gn_stream #(
  parameter int DATA_WIDTH       = 8,
  parameter int IMG_WIDTH        = 4,
  parameter int IMG_HEIGHT       = 4,
  parameter int CHANNEL_NUM      = 8,
  parameter int CHANNEL_IN_GROUP = 2,
  parameter int GROUP_NUM        = CHANNEL_NUM / CHANNEL_IN_GROUP,
  parameter int INV_FRAC         = 8,
  parameter int OUT_FRAC         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         end_of_frame,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(GROUP_NUM)-1:0] group_idx,
  output logic                         frame_err
);
  localparam int N     = CHANNEL_IN_GROUP * IMG_WIDTH * IMG_HEIGHT;
  localparam int LOG2N = $clog2(N);
  localparam int GW    = $clog2(GROUP_NUM);
  localparam int SW    = DATA_WIDTH + LOG2N;
  localparam int QW    = 2 * DATA_WIDTH + LOG2N;
  localparam int VW    = 2 * DATA_WIDTH;
  localparam int RW    = DATA_WIDTH + 4;  // sqrt partial remainder, with headroom
  localparam int DW2   = DATA_WIDTH + 2;  // divide partial remainder, with headroom
  localparam int QDW   = INV_FRAC + 1;    // 2^INV_FRAC / 1 needs one extra bit
  localparam int PW    = DATA_WIDTH + QDW + 2;
  localparam int SH    = INV_FRAC - OUT_FRAC;
  localparam int CW    = $clog2(DATA_WIDTH + INV_FRAC + 2);

  localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = -SAT_HI - 1;

  typedef enum logic [2:0] {StCollect, StStats, StSqrt, StDiv, StPrep, StEmit} state_e;

  state_e                       state;
  logic [DATA_WIDTH-1:0]        buffer [N];
  logic [LOG2N-1:0]             cnt, eidx, sel;
  logic signed [SW-1:0]         sum;
  logic [QW-1:0]                sumsq;
  logic signed [DATA_WIDTH-1:0] mean;
  logic [VW-1:0]                sq_rad;
  logic [RW-1:0]                sq_rem;
  logic [DATA_WIDTH-1:0]        sq_root, sd;
  logic [DW2-1:0]               dv_rem;
  logic [QDW-1:0]               inv_sd;
  logic [CW-1:0]                step;

  // Input side
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [VW-1:0]         x_sq;
  logic                         accept, group_last, frame_end;

  assign in_ready   = (state == StCollect) & ~reset;
  assign x          = $signed(data_in);
  assign x_sq       = x * x;
  assign accept     = in_valid & in_ready;
  assign group_last = (group_idx == GW'(GROUP_NUM - 1));
  assign frame_end  = (cnt == LOG2N'(N - 1)) && group_last;

  // Statistics: the upper slice of sum is floor(sum / N)
  logic signed [DATA_WIDTH-1:0] mean_c;
  logic [VW-1:0]                msq, var_c;
  logic signed [VW-1:0]         mean_sq;
  logic [VW:0]                  var_diff;

  assign mean_c   = sum[SW-1:LOG2N];
  assign msq      = sumsq[QW-1:LOG2N];
  assign mean_sq  = mean_c * mean_c;
  assign var_diff = {1'b0, msq} - {1'b0, mean_sq};
  assign var_c    = var_diff[VW] ? '0 : var_diff[VW-1:0];

  // Restoring sqrt step: two radicand bits per cycle
  logic [RW-1:0]         sq_cur, sq_trial, sq_rem_n;
  logic [DATA_WIDTH-1:0] sq_root_n;
  logic                  sq_ge;

  assign sq_cur    = (sq_rem << 2) | RW'(sq_rad[VW-1 -: 2]);
  assign sq_trial  = (RW'(sq_root) << 2) | RW'(1);
  assign sq_ge     = sq_cur >= sq_trial;
  assign sq_rem_n  = sq_ge ? sq_cur - sq_trial : sq_cur;
  assign sq_root_n = {sq_root[DATA_WIDTH-2:0], sq_ge};

  // Restoring divide step: dividend 2^INV_FRAC has a single 1 in its first bit
  logic [DW2-1:0] dv_cur, dv_rem_n;
  logic [QDW-1:0] inv_n;
  logic           dv_ge;

  assign dv_cur   = (dv_rem << 1) | DW2'(step == '0);
  assign dv_ge    = dv_cur >= DW2'(sd);
  assign dv_rem_n = dv_ge ? dv_cur - DW2'(sd) : dv_cur;
  assign inv_n    = {inv_sd[QDW-2:0], dv_ge};

  // Normalisation of the sample about to be presented
  logic signed [DATA_WIDTH-1:0] smp;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [PW-1:0]         prod, shifted;
  logic [DATA_WIDTH-1:0]        norm;

  assign sel     = (state == StEmit) ? eidx + 1'b1 : '0;
  assign smp     = $signed(buffer[sel]);
  assign diff    = {smp[DATA_WIDTH-1], smp} - {mean[DATA_WIDTH-1], mean};
  assign prod    = diff * $signed({1'b0, inv_sd});
  assign shifted = prod >>> SH;

  // Saturate the scaled value into the output sample range
  always_comb begin
    norm = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_HI) begin
      norm = SAT_HI[DATA_WIDTH-1:0];
    end else if (shifted < SAT_LO) begin
      norm = SAT_LO[DATA_WIDTH-1:0];
    end
  end

  // Group sample storage, written in arrival order
  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[cnt] <= data_in;
    end
  end

  // Control FSM with registered outputs and datapath state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StCollect;
      cnt       <= '0;
      eidx      <= '0;
      sum       <= '0;
      sumsq     <= '0;
      mean      <= '0;
      sq_rad    <= '0;
      sq_rem    <= '0;
      sq_root   <= '0;
      sd        <= '0;
      dv_rem    <= '0;
      inv_sd    <= '0;
      step      <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      group_idx <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        StCollect: begin
          if (accept) begin
            if (end_of_frame && !frame_end) begin
              // Early frame end: drop the partial group and restart the frame
              frame_err <= 1'b1;
              sum       <= '0;
              sumsq     <= '0;
              cnt       <= '0;
              group_idx <= '0;
            end else begin
              sum   <= sum + {{LOG2N{x[DATA_WIDTH-1]}}, x};
              sumsq <= sumsq + {{LOG2N{1'b0}}, x_sq};
              if (cnt == LOG2N'(N - 1)) begin
                cnt       <= '0;
                frame_err <= frame_end && !end_of_frame;
                state     <= StStats;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        StStats: begin
          mean    <= mean_c;
          sq_rad  <= var_c;
          sq_rem  <= '0;
          sq_root <= '0;
          step    <= '0;
          state   <= StSqrt;
        end
        StSqrt: begin
          sq_rad  <= sq_rad << 2;
          sq_rem  <= sq_rem_n;
          sq_root <= sq_root_n;
          if (step == CW'(DATA_WIDTH - 1)) begin
            sd     <= (|sq_root_n) ? sq_root_n : DATA_WIDTH'(1);
            dv_rem <= '0;
            inv_sd <= '0;
            step   <= '0;
            state  <= StDiv;
          end else begin
            step <= step + 1'b1;
          end
        end
        StDiv: begin
          dv_rem <= dv_rem_n;
          inv_sd <= inv_n;
          if (step == CW'(INV_FRAC)) begin
            state <= StPrep;
          end else begin
            step <= step + 1'b1;
          end
        end
        StPrep: begin
          data_out  <= norm;
          out_valid <= 1'b1;
          out_last  <= (sel == LOG2N'(N - 1)) && group_last;
          eidx      <= '0;
          state     <= StEmit;
        end
        StEmit: begin
          if (out_ready) begin
            if (eidx == LOG2N'(N - 1)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              sum       <= '0;
              sumsq     <= '0;
              cnt       <= '0;
              group_idx <= group_last ? '0 : group_idx + 1'b1;
              state     <= StCollect;
            end else begin
              eidx     <= eidx + 1'b1;
              data_out <= norm;
              out_last <= (sel == LOG2N'(N - 1)) && group_last;
            end
          end
        end
        default: state <= StCollect;
      endcase
    end
  end

endmodule

// File: tb/tb_gn_stream.sv
// tb_gn_stream: directed bench for gn_stream with hand-computed expectations.
module tb_gn_stream;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic       end_of_frame;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] group_idx;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] stim [32];
  logic [7:0] expv [32];

  gn_stream dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .end_of_frame (end_of_frame),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .group_idx    (group_idx),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [7:0] v, input logic eof);
    int b;
    b = 0;
    data_in      = v;
    end_of_frame = eof;
    in_valid     = 1'b1;
    while (!in_ready && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid     = 1'b0;
    end_of_frame = 1'b0;
    data_in      = 8'($urandom);
  endtask

  task automatic send_group(input int n, input int eof_at, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && i == 5) begin
        // Idle cycle with junk data that must not be absorbed
        in_valid = 1'b0;
        data_in  = 8'd100;
        tick();
      end
      send_sample(stim[i], i == eof_at);
    end
  endtask

  task automatic wait_valid(input int exp_lat);
    int c;
    int ir;
    c  = 0;
    ir = 0;
    while (!out_valid && c < 100) begin
      if (in_ready) ir++;
      tick();
      c++;
    end
    chk("first_valid_latency", 32'(c), 32'(exp_lat));
    chk("in_ready_low_busy", 32'(ir), 32'd0);
  endtask

  task automatic recv_group(input logic [1:0] gidx, input bit last_grp, input bit bp);
    int i, cyc, gbad, lbad, vbad, ibad;
    bit go;
    i = 0; cyc = 0; gbad = 0; lbad = 0; vbad = 0; ibad = 0;
    while (i < 32 && cyc < 2000) begin
      if (out_valid) begin
        chk("data_out", 32'(data_out), 32'(expv[i]));
        if (group_idx !== gidx) gbad++;
        if (out_last !== (last_grp && i == 31)) lbad++;
      end else begin
        vbad++;
      end
      if (in_ready) ibad++;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      go = out_valid && out_ready;
      tick();
      cyc++;
      if (go) i++;
    end
    out_ready = 1'b1;
    chk("emit_count", 32'(i), 32'd32);
    chk("group_idx_emit", 32'(gbad), 32'd0);
    chk("out_last_pos", 32'(lbad), 32'd0);
    chk("out_valid_held", 32'(vbad), 32'd0);
    chk("in_ready_emit", 32'(ibad), 32'd0);
    chk("out_valid_done", 32'(out_valid), 32'd0);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 32; i++) begin
      stim[i] = v;
      expv[i] = 8'h00;
    end
  endtask

  initial begin
    reset        = 1'b1;
    data_in      = 8'h00;
    in_valid     = 1'b0;
    end_of_frame = 1'b0;
    out_ready    = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_group_idx", 32'(group_idx), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Group 0: constant 5 -> sd forced to 1, all zeros
    fill_const(8'd5);
    send_group(32, -1, 1'b0);
    chk("g0_frame_err", 32'(frame_err), 32'd0);
    wait_valid(19);
    recv_group(2'd0, 1'b0, 1'b0);

    // Group 1: +4/-4 -> sd 4, inv 64, +/-16
    for (int i = 0; i < 32; i++) begin
      stim[i] = (i % 2 == 0) ? 8'd4 : 8'hFC;
      expv[i] = (i % 2 == 0) ? 8'd16 : 8'hF0;
    end
    send_group(32, -1, 1'b1);
    chk("g1_frame_err", 32'(frame_err), 32'd0);
    wait_valid(19);
    recv_group(2'd1, 1'b0, 1'b1);

    // Group 2: 31 zeros then 10 -> var 3, sd 1, last saturates to 127
    fill_const(8'd0);
    stim[31] = 8'd10;
    expv[31] = 8'd127;
    send_group(32, -1, 1'b0);
    chk("g2_frame_err", 32'(frame_err), 32'd0);
    wait_valid(19);
    recv_group(2'd2, 1'b0, 1'b1);

    // Group 3 ends the frame: 16x6, 16x0 -> mean 3, sd 3, inv 85 -> 15 / -16
    for (int i = 0; i < 32; i++) begin
      stim[i] = (i < 16) ? 8'd6 : 8'd0;
      expv[i] = (i < 16) ? 8'd15 : 8'hF0;
    end
    send_group(32, 31, 1'b0);
    chk("g3_frame_err", 32'(frame_err), 32'd0);
    wait_valid(19);
    recv_group(2'd3, 1'b1, 1'b1);
    chk("frame_wrap_idx", 32'(group_idx), 32'd0);

    // Early end_of_frame on sample 10 of group 1
    fill_const(8'd9);
    send_group(32, -1, 1'b0);
    wait_valid(19);
    recv_group(2'd0, 1'b0, 1'b0);
    fill_const(8'd33);
    send_group(10, 9, 1'b0);
    chk("eof_err_pulse", 32'(frame_err), 32'd1);
    tick();
    chk("eof_err_clear", 32'(frame_err), 32'd0);
    chk("eof_no_output", 32'(out_valid), 32'd0);
    chk("eof_in_ready", 32'(in_ready), 32'd1);
    chk("eof_group_idx", 32'(group_idx), 32'd0);

    // 31 zeros then -10 -> mean floor -1, var 2, sd 1 -> 16s and -128
    for (int i = 0; i < 32; i++) begin
      stim[i] = 8'd0;
      expv[i] = 8'd16;
    end
    stim[31] = 8'hF6;
    expv[31] = 8'h80;
    send_group(32, -1, 1'b0);
    chk("neg_frame_err", 32'(frame_err), 32'd0);
    wait_valid(19);
    recv_group(2'd0, 1'b0, 1'b0);

    // Reset while group 2 is in SQRT
    fill_const(8'd7);
    send_group(32, -1, 1'b0);
    wait_valid(19);
    recv_group(2'd1, 1'b0, 1'b0);
    fill_const(8'd5);
    send_group(32, -1, 1'b0);
    chk("pre_rst_idx", 32'(group_idx), 32'd2);
    repeat (5) tick();
    reset = 1'b1;
    #2;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_group_idx", 32'(group_idx), 32'd0);
    tick();
    tick();
    chk("mid_rst_out_valid2", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    fill_const(8'hFD);
    send_group(32, -1, 1'b0);
    wait_valid(19);
    recv_group(2'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
